// File: rtl/pc_fetch_unit.sv
// RV32I instruction-fetch front end: owns the fetch PC, keeps one imem request in flight,
// hands fetched words to decode over valid/ready, and squashes wrong-path fetches on redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_REQ     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DISCARD = 3'd3,
    ST_FAULT   = 3'd4,
    ST_WAIT    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ENTER_NONE  = 2'd0,
    ENTER_REQ   = 2'd1,
    ENTER_FAULT = 2'd2
  } enter_t;

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  state_t      state_r, state_nxt_s;
  logic [31:0] fetch_pc_r, fetch_pc_nxt_s;
  logic        pend_fault_r, pend_fault_nxt_s;
  logic        imem_req_r, imem_req_nxt_s;
  logic [31:0] imem_addr_r, imem_addr_nxt_s;
  logic        if_valid_r, if_valid_nxt_s;
  logic [31:0] if_pc_r, if_pc_nxt_s;
  logic [31:0] if_instr_r, if_instr_nxt_s;
  logic        if_fault_r, if_fault_nxt_s;
  enter_t      enter_s, redir_enter_s;
  logic [31:0] enter_pc_s;
  logic        accept_s;

  assign accept_s = if_valid_r & if_ready;

  // Next-state and next-output logic; a redirect outranks every other event.
  always_comb begin
    state_nxt_s      = state_r;
    fetch_pc_nxt_s   = fetch_pc_r;
    pend_fault_nxt_s = pend_fault_r;
    imem_req_nxt_s   = imem_req_r;
    imem_addr_nxt_s  = imem_addr_r;
    if_valid_nxt_s   = if_valid_r;
    if_pc_nxt_s      = if_pc_r;
    if_instr_nxt_s   = if_instr_r;
    if_fault_nxt_s   = if_fault_r;
    enter_s          = ENTER_NONE;
    enter_pc_s       = fetch_pc_r;
    redir_enter_s    = is_misaligned(redirect_target) ? ENTER_FAULT : ENTER_REQ;

    if (redirect_valid) begin
      fetch_pc_nxt_s   = redirect_target;
      pend_fault_nxt_s = is_misaligned(redirect_target);
      if_valid_nxt_s   = 1'b0;
      if_fault_nxt_s   = 1'b0;
      if_instr_nxt_s   = NOP_INSTR;
    end else begin
      pend_fault_nxt_s = pend_fault_r;
    end

    case (state_r)
      ST_BOOT: begin
        if (redirect_valid) begin
          enter_s    = redir_enter_s;
          enter_pc_s = redirect_target;
        end else begin
          enter_s    = ENTER_REQ;
          enter_pc_s = fetch_pc_r;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            enter_s    = redir_enter_s;
            enter_pc_s = redirect_target;
          end else begin
            // The request cannot be withdrawn; keep it stable and drop its data later.
            state_nxt_s = ST_DISCARD;
          end
        end else if (imem_ack) begin
          state_nxt_s    = ST_HOLD;
          imem_req_nxt_s = 1'b0;
          if_valid_nxt_s = 1'b1;
          if_pc_nxt_s    = fetch_pc_r;
          if_instr_nxt_s = imem_rdata;
          if_fault_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          enter_s    = redir_enter_s;
          enter_pc_s = redirect_target;
        end else if (accept_s) begin
          fetch_pc_nxt_s = fetch_pc_r + 32'd4;
          enter_s        = ENTER_REQ;
          enter_pc_s     = fetch_pc_r + 32'd4;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            enter_s    = redir_enter_s;
            enter_pc_s = redirect_target;
          end else begin
            state_nxt_s = ST_DISCARD;
          end
        end else if (imem_ack) begin
          enter_s    = pend_fault_r ? ENTER_FAULT : ENTER_REQ;
          enter_pc_s = fetch_pc_r;
        end else begin
          state_nxt_s = ST_DISCARD;
        end
      end
      ST_FAULT: begin
        if (redirect_valid) begin
          enter_s    = redir_enter_s;
          enter_pc_s = redirect_target;
        end else if (accept_s) begin
          state_nxt_s    = ST_WAIT;
          if_valid_nxt_s = 1'b0;
          if_fault_nxt_s = 1'b0;
          if_instr_nxt_s = NOP_INSTR;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          enter_s    = redir_enter_s;
          enter_pc_s = redirect_target;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s    = ST_BOOT;
        imem_req_nxt_s = 1'b0;
        if_valid_nxt_s = 1'b0;
      end
    endcase

    case (enter_s)
      ENTER_REQ: begin
        state_nxt_s     = ST_REQ;
        imem_req_nxt_s  = 1'b1;
        imem_addr_nxt_s = word_addr(enter_pc_s);
        if_valid_nxt_s  = 1'b0;
        if_fault_nxt_s  = 1'b0;
        if_instr_nxt_s  = NOP_INSTR;
      end
      ENTER_FAULT: begin
        // Misaligned target: present a faulting NOP instead of touching memory.
        state_nxt_s    = ST_FAULT;
        imem_req_nxt_s = 1'b0;
        if_valid_nxt_s = 1'b1;
        if_fault_nxt_s = 1'b1;
        if_pc_nxt_s    = enter_pc_s;
        if_instr_nxt_s = NOP_INSTR;
      end
      default: begin
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_BOOT;
      fetch_pc_r   <= RESET_PC;
      pend_fault_r <= 1'b0;
      imem_req_r   <= 1'b0;
      imem_addr_r  <= RESET_PC;
      if_valid_r   <= 1'b0;
      if_pc_r      <= RESET_PC;
      if_instr_r   <= NOP_INSTR;
      if_fault_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fetch_pc_r   <= fetch_pc_nxt_s;
      pend_fault_r <= pend_fault_nxt_s;
      imem_req_r   <= imem_req_nxt_s;
      imem_addr_r  <= imem_addr_nxt_s;
      if_valid_r   <= if_valid_nxt_s;
      if_pc_r      <= if_pc_nxt_s;
      if_instr_r   <= if_instr_nxt_s;
      if_fault_r   <= if_fault_nxt_s;
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = imem_addr_r;
  assign if_valid  = if_valid_r;
  assign if_pc     = if_pc_r;
  assign if_instr  = if_instr_r;
  assign if_fault  = if_fault_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed stimulus, a memory responder that checks
// request addresses, and a decode-side monitor that checks every presented fetch result.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XK  = 32'hA5A5_A5A5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  logic        mem_ack, man_ack, man_en, mem_hold;
  logic [31:0] mem_rdata, man_rdata;
  int          mem_wait;

  logic        imem_req_b, imem_ack_b, if_valid_b, if_fault_b;
  logic [31:0] imem_addr_b, imem_rdata_b, if_pc_b, if_instr_b;

  int          tests = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_if[$];
  logic [31:0] exp_req[$];
  int          ack_cyc[$];

  assign imem_ack   = man_en ? man_ack : mem_ack;
  assign imem_rdata = man_en ? man_rdata : mem_rdata;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_fault(if_fault)
  );

  // Second instance exercises the 32-bit wrap of the fetch PC with a zero-wait memory.
  assign imem_ack_b   = imem_req_b;
  assign imem_rdata_b = imem_addr_b ^ XK;

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(1'b0), .redirect_target(32'h0000_0000),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b),
    .imem_rdata(imem_rdata_b),
    .if_valid(if_valid_b), .if_ready(1'b1), .if_pc(if_pc_b), .if_instr(if_instr_b),
    .if_fault(if_fault_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.fault = fault;
    exp_if.push_back(e);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    man_en = 1'b0;
    mem_hold = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_if.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    mem_hold = 1'b1;
    chk({name, "_drain"}, 32'(exp_if.size()), 32'd0);
    chk({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
  endtask

  // Memory responder: acks after mem_wait stall cycles, checks address stability and order.
  initial begin
    int          wait_cnt;
    logic        pend;
    logic [31:0] paddr;
    wait_cnt = 0;
    pend = 1'b0;
    paddr = 32'h0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n !== 1'b1 || mem_hold) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
        pend = 1'b0;
      end else if (imem_req) begin
        if (pend) chk("req_addr_stable", imem_addr, paddr);
        chk("req_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (wait_cnt >= mem_wait) begin
          mem_ack = 1'b1;
          mem_rdata = imem_addr ^ XK;
          wait_cnt = 0;
          pend = 1'b0;
          ack_cyc.push_back(cyc);
          if (exp_req.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL req_unexpected: got request at %h, expected none", imem_addr);
          end else begin
            chk("req_addr", imem_addr, exp_req.pop_front());
          end
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
          pend = 1'b1;
          paddr = imem_addr;
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt = 0;
        pend = 1'b0;
      end
    end
  end

  // Decode-side monitor: pops the scoreboard on each handshake, checks stalls hold still.
  initial begin
    logic stall_prev;
    exp_t held, e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", 32'(if_valid), 32'd1);
          chk("stall_pc", if_pc, held.pc);
          chk("stall_instr", if_instr, held.instr);
          chk("stall_fault", 32'(if_fault), 32'(held.fault));
        end
        if (if_valid && if_ready && !redirect_valid) begin
          if (exp_if.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL if_unexpected: got pc %h instr %h, expected no output", if_pc, if_instr);
          end else begin
            e = exp_if.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_instr", if_instr, e.instr);
            chk("if_fault", 32'(if_fault), 32'(e.fault));
          end
        end else if (!if_valid) begin
          chk("idle_instr", if_instr, NOP);
        end
        stall_prev = if_valid && !if_ready && !redirect_valid;
        held.pc = if_pc;
        held.instr = if_instr;
        held.fault = if_fault;
      end
    end
  end

  // Wrap instance: first two results must be 0xFFFFFFFC then 0x00000000.
  initial begin
    logic [31:0] pcs[$];
    logic [31:0] ins[$];
    @(posedge rst_n);
    for (int i = 0; i < 20 && pcs.size() < 2; i++) begin
      @(negedge clk);
      if (if_valid_b) begin
        pcs.push_back(if_pc_b);
        ins.push_back(if_instr_b);
      end
    end
    chk("wrap_count", 32'(pcs.size()), 32'd2);
    if (pcs.size() == 2) begin
      chk("wrap_pc0", pcs[0], 32'hFFFF_FFFC);
      chk("wrap_instr0", ins[0], 32'h5A5A_5A59);
      chk("wrap_pc1", pcs[1], 32'h0000_0000);
      chk("wrap_instr1", ins[1], 32'hA5A5_A5A5);
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    if_ready = 1'b1;
    man_ack = 1'b0;
    man_rdata = 32'h0;
    mem_wait = 0;
    reset_dut();

    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_fault", 32'(if_fault), 32'd0);
    chk("rst_wrap_addr", imem_addr_b, 32'hFFFF_FFFC);

    // Zero-wait streaming, one instruction every two cycles.
    ack_cyc.delete();
    exp_req = '{32'h0, 32'h4, 32'h8, 32'hC};
    push_if(32'h0, 32'hA5A5_A5A5, 1'b0);
    push_if(32'h4, 32'hA5A5_A5A1, 1'b0);
    push_if(32'h8, 32'hA5A5_A5AD, 1'b0);
    push_if(32'hC, 32'hA5A5_A5A9, 1'b0);
    mem_hold = 1'b0;
    rst_n = 1'b1;
    wait_empty("t1");
    chk("t1_ack_count", 32'(ack_cyc.size()), 32'd4);
    for (int i = 1; i < ack_cyc.size(); i++) chk("t1_ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);

    // Wait-stated memory and a stalled decoder.
    reset_dut();
    exp_req = '{32'h0, 32'h4};
    push_if(32'h0, 32'hA5A5_A5A5, 1'b0);
    push_if(32'h4, 32'hA5A5_A5A1, 1'b0);
    mem_wait = 3;
    if_ready = 1'b0;
    mem_hold = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while (!if_valid && n < 30) begin tick(); n++; end
    chk("t2_first_valid", 32'(if_valid), 32'd1);
    repeat (5) tick();
    if_ready = 1'b1;
    wait_empty("t2");

    // Redirect while the request at 0x8 is still pending.
    reset_dut();
    exp_req = '{32'h0, 32'h4, 32'h8, 32'h100};
    push_if(32'h0, 32'hA5A5_A5A5, 1'b0);
    push_if(32'h4, 32'hA5A5_A5A1, 1'b0);
    push_if(32'h100, 32'hA5A5_A4A5, 1'b0);
    mem_wait = 2;
    mem_hold = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 32'h8) && n < 40) begin tick(); n++; end
    chk("t3_req8_seen", imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_discard_req", 32'(imem_req), 32'd1);
    chk("t3_discard_addr", imem_addr, 32'h8);
    wait_empty("t3");

    // Misaligned redirect from HOLD, then idle until a fresh redirect.
    reset_dut();
    exp_req = '{32'h0, 32'h200};
    push_if(32'h102, NOP, 1'b1);
    push_if(32'h200, 32'hA5A5_A7A5, 1'b0);
    mem_wait = 0;
    if_ready = 1'b0;
    mem_hold = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    chk("t4_hold_valid", 32'(if_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0102;
    if_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("t4_fault_valid", 32'(if_valid), 32'd1);
    chk("t4_fault_flag", 32'(if_fault), 32'd1);
    chk("t4_fault_noreq", 32'(imem_req), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_wait_noreq", 32'(imem_req), 32'd0);
      chk("t4_wait_novalid", 32'(if_valid), 32'd0);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    wait_empty("t4");

    // Reset asserted mid-request, followed by a late acknowledge.
    reset_dut();
    rst_n = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin tick(); n++; end
    chk("t5_req_up", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(imem_req), 32'd0);
    chk("t5_rst_addr", imem_addr, 32'h0);
    chk("t5_rst_valid", 32'(if_valid), 32'd0);
    chk("t5_rst_pc", if_pc, 32'h0);
    chk("t5_rst_instr", if_instr, NOP);
    chk("t5_rst_fault", 32'(if_fault), 32'd0);
    man_en = 1'b1;
    man_ack = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_restart_req", 32'(imem_req), 32'd1);
    chk("t5_restart_addr", imem_addr, 32'h0);
    chk("t5_restart_valid", 32'(if_valid), 32'd0);
    man_en = 1'b0;
    man_ack = 1'b0;
    exp_req = '{32'h0};
    push_if(32'h0, 32'hA5A5_A5A5, 1'b0);
    mem_wait = 0;
    mem_hold = 1'b0;
    wait_empty("t5");

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
